// File: rtl/if_prefetch_pkg.sv
// Shared types and bus definitions for the instruction prefetch unit.
// Defines the instruction/address bus ranges and boolean literals used across
// the prefetch files, plus the FSM encoding and queue entry layout.
`ifndef IF_PREFETCH_DEFINES
`define IF_PREFETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`define True 1'b1
`define False 1'b0
`endif

package if_prefetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    // Fetch FSM: nothing outstanding / one outstanding to keep / one to discard
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    // One queued instruction together with the address it was fetched from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } if_entry_t;

    // Sequential fetch address; wraps modulo 2^32
    function automatic logic [ADDR_W-1:0] next_fetch_pc(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Instruction queue for the prefetch unit: power-of-two circular buffer with
// push/pop/flush and an occupancy count. Flush and reset empty the queue.
module if_inst_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  if_entry_t        push_data,
    output if_entry_t        head,
    output logic [CNT_W-1:0] count
);

    if_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: issues one fetch at a time to the memory
// controller, queues returned instructions and presents them to IF/ID.
// A branch interception flushes the queue and discards any in-flight response.
// Optional feature macro: IF_PREFETCH_BYPASS_EN -- a response arriving while
// the queue is empty is presented in the same cycle and, if accepted, never
// enters the queue.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [`InstAddrBus] mem_addr,
    input  logic                mem_grant,
    input  logic [1:0]          memcnf,
    input  logic                mem_valid,
    input  logic [`InstBus]     mem_inst,
    input  logic                branch_interception,
    input  logic [`InstAddrBus] branch_target,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [`InstAddrBus] if_pc,
    output logic [`InstBus]     if_inst,
    output logic                if_stall
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if_state_e          state;
    if_state_e          state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               issue;
    logic               push;
    logic               pop;
    logic               bypass_hit;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    if_entry_t          fifo_head;
    if_entry_t          push_data;

    if_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (branch_interception),
        .push_data (push_data),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign fifo_empty = (fifo_count == CNT_W'(0));
    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign push_data  = '{pc: req_pc, inst: mem_inst};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a response always returns to IDLE, even alongside a flush
    always_comb begin
        state_next = state;
        case (state)
            IF_IDLE: begin
                if (issue) begin
                    state_next = IF_WAIT;
                end else begin
                    state_next = IF_IDLE;
                end
            end
            IF_WAIT: begin
                if (mem_valid) begin
                    state_next = IF_IDLE;
                end else if (branch_interception) begin
                    state_next = IF_DROP;
                end else begin
                    state_next = IF_WAIT;
                end
            end
            IF_DROP: begin
                if (mem_valid) begin
                    state_next = IF_IDLE;
                end else begin
                    state_next = IF_DROP;
                end
            end
            default: state_next = IF_IDLE;
        endcase
    end

    // FSM outputs: request issue, queue push/pop and the presented instruction
    always_comb begin
        mem_req  = (state == IF_IDLE) && (memcnf == 2'b00) && !branch_interception
                   && !fifo_full && !rst;
        mem_addr = fetch_pc;
        issue    = mem_req && mem_grant;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass_hit = (state == IF_WAIT) && fifo_empty && mem_valid && !branch_interception;
`else
        bypass_hit = `False;
`endif
        if_valid = !rst && !branch_interception && (!fifo_empty || bypass_hit);
        pop      = if_valid && id_ready && !fifo_empty;
        push     = (state == IF_WAIT) && mem_valid && !branch_interception && !rst
                   && !(bypass_hit && id_ready);
        if (!if_valid) begin
            if_pc   = '0;
            if_inst = '0;
        end else if (!fifo_empty) begin
            if_pc   = fifo_head.pc;
            if_inst = fifo_head.inst;
        end else begin
`ifdef IF_PREFETCH_BYPASS_EN
            if_pc   = req_pc;
            if_inst = mem_inst;
`else
            if_pc   = '0;
            if_inst = '0;
`endif
        end
        if_stall = !if_valid;
    end

    // Fetch address and in-flight request address
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (branch_interception) begin
            fetch_pc <= branch_target;
            req_pc   <= req_pc;
        end else if (issue) begin
            fetch_pc <= next_fetch_pc(fetch_pc);
            req_pc   <= fetch_pc;
        end else begin
            fetch_pc <= fetch_pc;
            req_pc   <= req_pc;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a memory model answers grants, every
// grant pushes the expected {pc, inst} to a scoreboard, and every accepted
// presentation pops and compares. Branch/reset clear the scoreboard.
module tb_if_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [1:0]  memcnf;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic        branch_interception;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] consumed_q[$];
    logic [31:0] exp_fetch_pc;
    bit          auto_resp;
    bit          drop_en;
    logic [31:0] drop_addr;
    bit          issued;
    logic [31:0] iss_addr;
    int          n_consumed;
    logic [31:0] last_pc;

    if_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_grant           (mem_grant),
        .memcnf              (memcnf),
        .mem_valid           (mem_valid),
        .mem_inst            (mem_inst),
        .branch_interception (branch_interception),
        .branch_target       (branch_target),
        .id_ready            (id_ready),
        .if_valid            (if_valid),
        .if_pc               (if_pc),
        .if_inst             (if_inst),
        .if_stall            (if_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // One clock: check outputs at negedge, record grants, then drive the response
    task automatic cycle();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        @(negedge clk);
        n_tests++;
        if (if_stall !== !if_valid) begin
            n_fail++;
            $display("FAIL stall: if_stall=%b if_valid=%b", if_stall, if_valid);
        end
        if (!if_valid) begin
            n_tests++;
            if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_zero: pc=%h inst=%h, required 0/0", if_pc, if_inst);
            end
        end
        if (if_valid && id_ready) begin
            n_tests++;
            if (exp_pc_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h, none expected", if_pc);
            end else begin
                e_pc   = exp_pc_q.pop_front();
                e_inst = exp_inst_q.pop_front();
                if (if_pc !== e_pc || if_inst !== e_inst) begin
                    n_fail++;
                    $display("FAIL sb_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                             if_pc, if_inst, e_pc, e_inst);
                end
            end
            n_consumed++;
            last_pc = if_pc;
            consumed_q.push_back(if_pc);
        end
        issued = mem_req && mem_grant;
        if (issued) begin
            n_tests++;
            if (mem_addr !== exp_fetch_pc) begin
                n_fail++;
                $display("FAIL fetch_addr: got %h, required %h", mem_addr, exp_fetch_pc);
            end
            iss_addr = mem_addr;
            exp_pc_q.push_back(mem_addr);
            exp_inst_q.push_back(inst_of(mem_addr));
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (auto_resp) begin
            mem_valid = issued && !(drop_en && iss_addr == drop_addr);
            mem_inst  = mem_valid ? inst_of(iss_addr) : 32'h0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        branch_interception = 1'b0;
        memcnf = 2'b00;
        mem_valid = 1'b0;
        mem_inst = 32'h0;
        id_ready = 1'b0;
        drop_en = 1'b0;
        exp_pc_q.delete();
        exp_inst_q.delete();
        cycle();
        rst = 1'b0;
        exp_pc_q.delete();
        exp_inst_q.delete();
        consumed_q.delete();
        exp_fetch_pc = RESET_PC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        auto_resp = 1'b1;
        id_ready = 1'b1;
        mem_valid = 1'b1;
        mem_inst = 32'hFFFF_FFFF;
        #2;
        n_tests++;
        if (mem_req !== 1'b0 || if_valid !== 1'b0 || if_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cycle: req=%b valid=%b stall=%b, required 0/0/1",
                     mem_req, if_valid, if_stall);
        end
        reset_dut();
        #1;
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: req=%b addr=%h valid=%b, required 1/%h/0",
                     mem_req, mem_addr, if_valid, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int n0;
        reset_dut();
        auto_resp = 1'b1;
        id_ready = 1'b1;
        n0 = n_consumed;
        for (int i = 0; i < 24; i++) cycle();
        n_tests++;
        if (n_consumed - n0 < 10) begin
            n_fail++;
            $display("FAIL stream_rate: consumed %0d, required >= 10", n_consumed - n0);
        end
        for (int i = 1; i < consumed_q.size(); i++) begin
            n_tests++;
            if (consumed_q[i] !== consumed_q[i-1] + 32'd4) begin
                n_fail++;
                $display("FAIL stream_seq: pc %h after %h", consumed_q[i], consumed_q[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        auto_resp = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (if_valid) begin
                n_tests++;
                if (if_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL bp_head_stable: pc=%h, required 0", if_pc);
                end
            end
        end
        n_tests++;
        if (exp_pc_q.size() != 4 || mem_req !== 1'b0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: grants=%0d req=%b valid=%b, required 4/0/1",
                     exp_pc_q.size(), mem_req, if_valid);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 30 && consumed_q.size() < 5; i++) cycle();
        n_tests++;
        if (consumed_q.size() < 5) begin
            n_fail++;
            $display("FAIL bp_release: consumed %0d, required 5", consumed_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (consumed_q[i] !== 32'(i * 4)) begin
                    n_fail++;
                    $display("FAIL bp_order: slot %0d pc=%h, required %h", i, consumed_q[i], 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_branch();
        bit found;
        int n0;
        reset_dut();
        auto_resp = 1'b1;
        id_ready = 1'b1;
        drop_en = 1'b1;
        drop_addr = 32'h8;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (issued && iss_addr == 32'h8) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL br_setup: fetch of pc 8 not seen, required 1");
        end
        branch_interception = 1'b1;
        branch_target = 32'h100;
        exp_pc_q.delete();
        exp_inst_q.delete();
        exp_fetch_pc = 32'h100;
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL br_cycle: valid=%b req=%b, required 0/0", if_valid, mem_req);
        end
        cycle();
        branch_interception = 1'b0;
        mem_valid = 1'b1;
        mem_inst = inst_of(32'h8);
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL br_drop: req=%b addr=%h, required 0/00000100", mem_req, mem_addr);
        end
        cycle();
        drop_en = 1'b0;
        n0 = n_consumed;
        for (int i = 0; i < 20 && n_consumed == n0; i++) cycle();
        n_tests++;
        if (n_consumed == n0 || consumed_q[consumed_q.size()-1] !== 32'h100) begin
            n_fail++;
            $display("FAIL br_target: first pc after flush=%h, required 00000100", last_pc);
        end
    endtask

    task automatic test_memcnf();
        logic [31:0] hold_addr;
        bit          resumed;
        reset_dut();
        auto_resp = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        memcnf = 2'b01;
        #1;
        hold_addr = mem_addr;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (mem_req !== 1'b0 || mem_addr !== hold_addr) begin
                n_fail++;
                $display("FAIL memcnf_block: req=%b addr=%h, required 0/%h", mem_req, mem_addr, hold_addr);
            end
            cycle();
        end
        memcnf = 2'b00;
        resumed = 1'b0;
        for (int i = 0; i < 6 && !resumed; i++) begin
            cycle();
            if (issued) resumed = 1'b1;
        end
        n_tests++;
        if (!resumed || iss_addr !== hold_addr) begin
            n_fail++;
            $display("FAIL memcnf_resume: addr=%h, required %h", iss_addr, hold_addr);
        end
    endtask

    task automatic test_latency();
        reset_dut();
        auto_resp = 1'b0;
        id_ready = 1'b1;
        cycle();
        mem_valid = 1'b1;
        mem_inst = inst_of(32'h0);
        #2;
        n_tests++;
`ifdef IF_PREFETCH_BYPASS_EN
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== inst_of(32'h0)) begin
`else
        if (if_valid !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL lat_same_cycle: valid=%b pc=%h inst=%h", if_valid, if_pc, if_inst);
        end
        cycle();
        mem_valid = 1'b0;
        mem_inst = 32'h0;
        #2;
        n_tests++;
`ifdef IF_PREFETCH_BYPASS_EN
        if (if_valid !== 1'b0) begin
`else
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== inst_of(32'h0)) begin
`endif
            n_fail++;
            $display("FAIL lat_next_cycle: valid=%b pc=%h inst=%h", if_valid, if_pc, if_inst);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        bit found;
        int n0;
        reset_dut();
        auto_resp = 1'b1;
        id_ready = 1'b0;
        drop_en = 1'b1;
        drop_addr = 32'hC;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (issued && iss_addr == 32'hC) found = 1'b1;
        end
        #1;
        n_tests++;
        if (!found || if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_setup: found=%b valid=%b pc=%h, required 1/1/0", found, if_valid, if_pc);
        end
        rst = 1'b1;
        exp_pc_q.delete();
        exp_inst_q.delete();
        cycle();
        rst = 1'b0;
        drop_en = 1'b0;
        exp_fetch_pc = RESET_PC;
        mem_valid = 1'b1;
        mem_inst = inst_of(32'hC);
        #2;
        n_tests++;
        if (if_valid !== 1'b0 || mem_addr !== RESET_PC || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_after: valid=%b addr=%h req=%b, required 0/%h/1",
                     if_valid, mem_addr, mem_req, RESET_PC);
        end
        cycle();
        id_ready = 1'b1;
        n0 = n_consumed;
        for (int i = 0; i < 10 && n_consumed == n0; i++) cycle();
        n_tests++;
        if (n_consumed == n0 || last_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL rm_first: pc=%h, required %h", last_pc, RESET_PC);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_grant = 1'b1;
        memcnf = 2'b00;
        mem_valid = 1'b0;
        mem_inst = 32'h0;
        branch_interception = 1'b0;
        branch_target = 32'h0;
        id_ready = 1'b0;
        auto_resp = 1'b1;
        drop_en = 1'b0;
        drop_addr = 32'h0;
        iss_addr = 32'h0;
        issued = 1'b0;
        n_consumed = 0;
        last_pc = 32'h0;
        exp_fetch_pc = RESET_PC;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_memcnf();
        test_latency();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule
